// File: rtl/ac_motor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ac_motor_pkg : shared constants/types for the SVPWM generator        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ac_motor_pkg;

  localparam int DEF_PERIOD   = 20000;
  localparam int DEF_DEADTIME = 50;

  localparam logic [2:0] SEC_1 = 3'd1;
  localparam logic [2:0] SEC_2 = 3'd2;
  localparam logic [2:0] SEC_3 = 3'd3;
  localparam logic [2:0] SEC_4 = 3'd4;
  localparam logic [2:0] SEC_5 = 3'd5;
  localparam logic [2:0] SEC_6 = 3'd6;

  localparam int PH_U = 0;
  localparam int PH_V = 1;
  localparam int PH_W = 2;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage
`default_nettype wire

// File: rtl/ac_motor_deadtime.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ac_motor_deadtime : per-leg reference register with dead-time insert |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ac_motor_deadtime #(
  parameter int DEADTIME = 50,
  parameter int DT_WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_ref,
  output logic o_hi,
  output logic o_lo
);

  localparam logic [DT_WIDTH-1:0] c_DT = DT_WIDTH'(DEADTIME);

  logic                r_ref;
  logic [DT_WIDTH-1:0] r_cnt;
  logic [DT_WIDTH-1:0] w_cnt_nxt;
  logic                w_settled;

  // r_cnt = cycles the reference has held its current level, saturating at c_DT
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_ref != r_ref) begin
      w_cnt_nxt = '0;
    end else if (r_cnt < c_DT) begin
      w_cnt_nxt = r_cnt + DT_WIDTH'(1);
    end
    w_settled = (w_cnt_nxt >= c_DT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ref <= 1'b0;
      r_cnt <= '0;
      o_hi  <= 1'b0;
      o_lo  <= 1'b0;
    end else begin
      r_ref <= i_ref;
      r_cnt <= w_cnt_nxt;
      o_hi  <= i_ref & w_settled;
      o_lo  <= ~i_ref & w_settled;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ac_motor_svpwm_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ac_motor_svpwm_gen : center-aligned space-vector PWM, 3-leg bridge   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ac_motor_svpwm_gen
  import ac_motor_pkg::*;
#(
  parameter int T_WIDTH  = 15,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int DEADTIME = DEF_DEADTIME,
  parameter int DT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [2:0]         sector,
  input  logic [T_WIDTH-1:0] t1,
  input  logic [T_WIDTH-1:0] t2,
  output logic               pwm_u_hi,
  output logic               pwm_u_lo,
  output logic               pwm_v_hi,
  output logic               pwm_v_lo,
  output logic               pwm_w_hi,
  output logic               pwm_w_lo,
  output logic               sync,
  output logic               overmod,
  output logic               sector_err
);

  localparam logic [T_WIDTH-1:0] c_PERIOD = T_WIDTH'(PERIOD);
  localparam logic [T_WIDTH-1:0] c_PEAK   = T_WIDTH'(PERIOD - 1);

  logic [T_WIDTH-1:0] r_cnt;
  dir_t               r_dir;
  logic               r_run;
  logic [2:0]         r_sec;
  logic [T_WIDTH-1:0] r_t1s;
  logic [T_WIDTH-1:0] r_t2s;
  logic               r_sync;
  logic               r_overmod;
  logic               r_sector_err;

  logic               w_load;
  logic [T_WIDTH:0]   w_sum;
  logic [T_WIDTH-1:0] w_t1n;
  logic [T_WIDTH-1:0] w_t2n;
  logic               w_om;
  logic               w_se;
  logic [T_WIDTH-1:0] w_t0;
  logic [T_WIDTH-1:0] w_x;
  logic [T_WIDTH-1:0] w_y;
  logic [T_WIDTH-1:0] w_z;
  logic [T_WIDTH-1:0] w_cmp [3];
  logic               w_sec_ok;
  logic               w_dt_rst_n;
  logic [2:0]         w_ref;
  logic [2:0]         w_hi;
  logic [2:0]         w_lo;

  // Load at the down->up valley, or on the first running cycle after reset/enable
  assign w_load = !r_run || ((r_dir == DIR_DOWN) && (r_cnt == '0));

  always_comb begin
    w_sum = {1'b0, t1} + {1'b0, t2};
    w_t1n = t1;
    w_t2n = t2;
    w_om  = 1'b0;
    if (t1 > c_PERIOD) begin
      w_t1n = c_PERIOD;
      w_t2n = '0;
      w_om  = 1'b1;
    end else if (w_sum > {1'b0, c_PERIOD}) begin
      w_t2n = c_PERIOD - t1;
      w_om  = 1'b1;
    end
    w_se = (sector == 3'd0) || (sector == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) begin
      r_cnt        <= '0;
      r_dir        <= DIR_UP;
      r_run        <= 1'b0;
      r_sec        <= 3'd0;
      r_t1s        <= '0;
      r_t2s        <= '0;
      r_sync       <= 1'b0;
      r_overmod    <= 1'b0;
      r_sector_err <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_sync <= 1'b0;
      if (w_load) begin
        r_sec        <= sector;
        r_t1s        <= w_t1n;
        r_t2s        <= w_t2n;
        r_sync       <= 1'b1;
        r_overmod    <= w_om;
        r_sector_err <= w_se;
      end
      // Extrema are held for two cycles: the direction flips instead of counting
      if (r_run) begin
        case (r_dir)
          DIR_UP: begin
            if (r_cnt == c_PEAK) r_dir <= DIR_DOWN;
            else                 r_cnt <= r_cnt + T_WIDTH'(1);
          end
          default: begin
            if (r_cnt == '0) r_dir <= DIR_UP;
            else             r_cnt <= r_cnt - T_WIDTH'(1);
          end
        endcase
      end
    end
  end

  always_comb begin
    w_t0 = c_PERIOD - r_t1s - r_t2s;
    w_x  = w_t0 >> 1;
    w_y  = r_sec[0] ? (w_x + r_t1s) : (w_x + r_t2s);
    w_z  = w_x + r_t1s + r_t2s;
  end

  always_comb begin
    w_sec_ok    = 1'b1;
    w_cmp[PH_U] = c_PERIOD;
    w_cmp[PH_V] = c_PERIOD;
    w_cmp[PH_W] = c_PERIOD;
    case (r_sec)
      SEC_1: begin w_cmp[PH_U] = w_x; w_cmp[PH_V] = w_y; w_cmp[PH_W] = w_z; end
      SEC_2: begin w_cmp[PH_V] = w_x; w_cmp[PH_U] = w_y; w_cmp[PH_W] = w_z; end
      SEC_3: begin w_cmp[PH_V] = w_x; w_cmp[PH_W] = w_y; w_cmp[PH_U] = w_z; end
      SEC_4: begin w_cmp[PH_W] = w_x; w_cmp[PH_V] = w_y; w_cmp[PH_U] = w_z; end
      SEC_5: begin w_cmp[PH_W] = w_x; w_cmp[PH_U] = w_y; w_cmp[PH_V] = w_z; end
      SEC_6: begin w_cmp[PH_U] = w_x; w_cmp[PH_W] = w_y; w_cmp[PH_V] = w_z; end
      default: w_sec_ok = 1'b0;
    endcase
  end

  assign w_dt_rst_n = reset_n & enable;

  for (genvar gi = 0; gi < 3; gi++) begin : g_leg
    assign w_ref[gi] = w_sec_ok & (r_cnt >= w_cmp[gi]);

    ac_motor_deadtime #(
      .DEADTIME (DEADTIME),
      .DT_WIDTH (DT_WIDTH)
    ) u_dt (
      .clk     (clk),
      .reset_n (w_dt_rst_n),
      .i_ref   (w_ref[gi]),
      .o_hi    (w_hi[gi]),
      .o_lo    (w_lo[gi])
    );
  end

  assign pwm_u_hi   = w_hi[PH_U];
  assign pwm_u_lo   = w_lo[PH_U];
  assign pwm_v_hi   = w_hi[PH_V];
  assign pwm_v_lo   = w_lo[PH_V];
  assign pwm_w_hi   = w_hi[PH_W];
  assign pwm_w_lo   = w_lo[PH_W];
  assign sync       = r_sync;
  assign overmod    = r_overmod;
  assign sector_err = r_sector_err;

endmodule
`default_nettype wire
